// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared definitions for the fetch/branch path: branch-op
//               encodings used by the decoder, branch_unit and pc_sequencer,
//               and the pc_sequencer state type.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // Decoded branch operation encodings
    localparam logic [4:0] BR_NOP = 5'd0;
    localparam logic [4:0] BR_EQ  = 5'd1;
    localparam logic [4:0] BR_NE  = 5'd2;
    localparam logic [4:0] BR_LT  = 5'd3;
    localparam logic [4:0] BR_GE  = 5'd4;
    localparam logic [4:0] BR_LTU = 5'd5;
    localparam logic [4:0] BR_GEU = 5'd6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_EXEC   = 3'd2,
        ST_HALTED = 3'd3,
        ST_TRAP   = 3'd4
    } pcseq_state_t;

endpackage
`default_nettype wire

// File: rtl/next_pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : next_pc_gen
// Description : Combinational next-PC resolution: target mux, adders and
//               misalignment check.
// Ports       : pc, imm, ru_X1     - current PC, immediate, JALR base
//               BrOp, branch_taken - decoded branch op and its outcome
//               jump, jalr         - JAL / JALR controls
//               target             - resolved next PC
//               pc_plus4           - sequential PC / link value
//               redirect           - target chosen other than pc+4
//               target_misaligned  - target[1:0] != 0
// Revision    : 1.0 - initial release
// ============================================================================
module next_pc_gen
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] ru_X1,
    input  logic [4:0]      BrOp,
    input  logic            branch_taken,
    input  logic            jump,
    input  logic            jalr,
    output logic [XLEN-1:0] target,
    output logic [XLEN-1:0] pc_plus4,
    output logic            redirect,
    output logic            target_misaligned
);

    logic [XLEN-1:0] w_pc_rel;
    logic [XLEN-1:0] w_jalr_sum;
    logic            w_br_taken;

    // All sums wrap modulo 2^XLEN by construction
    assign pc_plus4   = pc + {{(XLEN-3){1'b0}}, 3'b100};
    assign w_pc_rel   = pc + imm;
    assign w_jalr_sum = ru_X1 + imm;

    // A branch outcome only matters when a real branch op is decoded
    assign w_br_taken = (BrOp != BR_NOP) && branch_taken;

    always_comb begin
        target   = pc_plus4;
        redirect = 1'b0;
        if (jalr) begin
            target   = {w_jalr_sum[XLEN-1:1], 1'b0};
            redirect = 1'b1;
        end else if (jump || w_br_taken) begin
            target   = w_pc_rel;
            redirect = 1'b1;
        end
    end

    assign target_misaligned = (target[1:0] != 2'b00);

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Multi-cycle program-counter sequencer. Drives instruction
//               fetch, resolves the next PC, counts retired instructions
//               and taken control transfers, traps on misaligned targets.
// Ports       : clk, rst_n           - clock, async active-low reset
//               imem_req/addr/valid  - instruction fetch handshake
//               instr_valid          - instruction usable this cycle (EXEC)
//               BrOp, branch_taken   - branch op and branch_unit result
//               jump, jalr, imm      - jump controls and immediate
//               ru_X1                - JALR base register
//               halt, stall          - ECALL/EBREAK, hold in EXEC
//               pc, pc_plus4         - current PC and link value
//               misaligned, halted   - sticky trap flag, halted state
//               retired_cnt          - retired instruction count
//               taken_cnt            - taken branch/jump count
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_valid,
    output logic            instr_valid,
    input  logic [4:0]      BrOp,
    input  logic            branch_taken,
    input  logic            jump,
    input  logic            jalr,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] ru_X1,
    input  logic            halt,
    input  logic            stall,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misaligned,
    output logic            halted,
    output logic [31:0]     retired_cnt,
    output logic [31:0]     taken_cnt
);

    pcseq_state_t    r_state;
    pcseq_state_t    w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_retired_cnt;
    logic [31:0]     r_taken_cnt;
    logic            r_misaligned;

    logic [XLEN-1:0] w_target;
    logic            w_redirect;
    logic            w_target_mis;
    logic            w_retire;
    logic            w_trap;

    next_pc_gen #(
        .XLEN (XLEN)
    ) u_next_pc_gen (
        .pc                (r_pc),
        .imm               (imm),
        .ru_X1             (ru_X1),
        .BrOp              (BrOp),
        .branch_taken      (branch_taken),
        .jump              (jump),
        .jalr              (jalr),
        .target            (w_target),
        .pc_plus4          (pc_plus4),
        .redirect          (w_redirect),
        .target_misaligned (w_target_mis)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state plus the two EXEC-exit strobes that update the datapath
    always_comb begin
        w_state_next = r_state;
        w_retire     = 1'b0;
        w_trap       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_valid) begin
                    w_state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!stall) begin
                    if (halt) begin
                        w_state_next = ST_HALTED;
                    end else if (w_target_mis) begin
                        w_state_next = ST_TRAP;
                        w_trap       = 1'b1;
                    end else begin
                        w_state_next = ST_FETCH;
                        w_retire     = 1'b1;
                    end
                end
            end
            default: begin
                // HALTED and TRAP hold until reset
                w_state_next = r_state;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_retired_cnt <= 32'd0;
            r_taken_cnt   <= 32'd0;
            r_misaligned  <= 1'b0;
        end else begin
            if (w_retire) begin
                r_pc          <= w_target;
                r_retired_cnt <= r_retired_cnt + 32'd1;
                if (w_redirect) begin
                    r_taken_cnt <= r_taken_cnt + 32'd1;
                end
            end
            if (w_trap) begin
                r_misaligned <= 1'b1;
            end
        end
    end

    // Handshake outputs decode state only, so no input reaches them directly
    assign imem_req    = (r_state == ST_FETCH);
    assign instr_valid = (r_state == ST_EXEC);
    assign halted      = (r_state == ST_HALTED);
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign misaligned  = r_misaligned;
    assign retired_cnt = r_retired_cnt;
    assign taken_cnt   = r_taken_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer. A behavioural model
//               predicts every output each cycle; directed literal checks
//               pin the key points of each scenario. A second instance with
//               a wrap-around reset PC covers PC overflow and async reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;
    import riscv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic        instr_valid;
    logic [4:0]  BrOp;
    logic        branch_taken;
    logic        jump;
    logic        jalr;
    logic [31:0] imm;
    logic [31:0] ru_X1;
    logic        halt;
    logic        stall;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misaligned;
    logic        halted;
    logic [31:0] retired_cnt;
    logic [31:0] taken_cnt;

    // Second instance: wrap-around reset PC, sequential only
    logic        rst2_n;
    logic        imem_valid2;
    logic [4:0]  brop2;
    logic        zero2;
    logic [31:0] zero32_2;
    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic        instr_valid2;
    logic [31:0] pc2;
    logic [31:0] pc_plus4_2;
    logic        misaligned2;
    logic        halted2;
    logic [31:0] retired2;
    logic [31:0] taken2;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 0;

    pc_sequencer #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .instr_valid(instr_valid), .BrOp(BrOp),
        .branch_taken(branch_taken), .jump(jump), .jalr(jalr), .imm(imm),
        .ru_X1(ru_X1), .halt(halt), .stall(stall), .pc(pc), .pc_plus4(pc_plus4),
        .misaligned(misaligned), .halted(halted), .retired_cnt(retired_cnt),
        .taken_cnt(taken_cnt)
    );

    pc_sequencer #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst_n(rst2_n), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_valid(imem_valid2), .instr_valid(instr_valid2), .BrOp(brop2),
        .branch_taken(zero2), .jump(zero2), .jalr(zero2), .imm(zero32_2),
        .ru_X1(zero32_2), .halt(zero2), .stall(zero2), .pc(pc2),
        .pc_plus4(pc_plus4_2), .misaligned(misaligned2), .halted(halted2),
        .retired_cnt(retired2), .taken_cnt(taken2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: which phase the sequencer is in, and the
    // architectural PC / counters that the rules say it must hold.
    // ------------------------------------------------------------------
    localparam int P_IDLE = 0, P_FETCH = 1, P_EXEC = 2, P_HALT = 3, P_TRAP = 4;
    int          m_phase;
    logic [31:0] m_pc, m_ret, m_tak;
    logic        m_mis;

    function automatic logic [32:0] model_next(input logic [31:0] cur, input logic [4:0] op,
                                               input logic bt, input logic j, input logic jr,
                                               input logic [31:0] im, input logic [31:0] x1);
        logic [31:0] sum;
        if (jr) begin
            sum = x1 + im;
            return {1'b1, sum & 32'hFFFF_FFFE};
        end
        if (j) return {1'b1, cur + im};
        if (op != 5'd0 && bt) return {1'b1, cur + im};
        return {1'b0, cur + 32'd4};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [32:0] nx;
        if (!rst_n) begin
            m_phase = P_IDLE;
            m_pc    = 32'h0;
            m_ret   = 32'h0;
            m_tak   = 32'h0;
            m_mis   = 1'b0;
        end else begin
            case (m_phase)
                P_IDLE:  m_phase = P_FETCH;
                P_FETCH: if (imem_valid) m_phase = P_EXEC;
                P_EXEC: begin
                    if (!stall) begin
                        if (halt) begin
                            m_phase = P_HALT;
                        end else begin
                            nx = model_next(m_pc, BrOp, branch_taken, jump, jalr, imm, ru_X1);
                            if (nx[1:0] != 2'b00) begin
                                m_mis   = 1'b1;
                                m_phase = P_TRAP;
                            end else begin
                                m_pc    = nx[31:0];
                                m_ret   = m_ret + 32'd1;
                                if (nx[32]) m_tak = m_tak + 32'd1;
                                m_phase = P_FETCH;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_pc",          pc,                    m_pc);
            chk("m_pc_plus4",    pc_plus4,              m_pc + 32'd4);
            chk("m_imem_addr",   imem_addr,             m_pc);
            chk("m_imem_req",    32'(imem_req),         32'(m_phase == P_FETCH));
            chk("m_instr_valid", 32'(instr_valid),      32'(m_phase == P_EXEC));
            chk("m_halted",      32'(halted),           32'(m_phase == P_HALT));
            chk("m_misaligned",  32'(misaligned),       32'(m_mis));
            chk("m_retired",     retired_cnt,           m_ret);
            chk("m_taken",       taken_cnt,             m_tak);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called at a negedge, return at a negedge)
    // ------------------------------------------------------------------
    task automatic wait_exec();
        int k = 0;
        while (!instr_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!instr_valid) chk("exec_timeout", 32'(instr_valid), 32'd1);
    endtask

    task automatic clear_ctl();
        BrOp = BR_NOP; branch_taken = 0; jump = 0; jalr = 0;
        imm = 0; ru_X1 = 0; halt = 0; stall = 0;
    endtask

    task automatic exec_instr(input logic [4:0] op, input logic bt, input logic j,
                              input logic jr, input logic [31:0] im,
                              input logic [31:0] x1, input logic h);
        wait_exec();
        BrOp = op; branch_taken = bt; jump = j; jalr = jr;
        imm = im; ru_X1 = x1; halt = h;
        @(negedge clk);
        clear_ctl();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [31:0] addr_seen [3];
    logic [31:0] addr_exp  [3];
    int          cnt;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        addr_exp[0] = 32'h0; addr_exp[1] = 32'h4; addr_exp[2] = 32'h8;
        clear_ctl();
        imem_valid = 1'b1;
        rst_n = 1'b0;
        rst2_n = 1'b0; imem_valid2 = 1'b1; brop2 = BR_NOP; zero2 = 1'b0; zero32_2 = 32'h0;
        repeat (3) @(negedge clk);
        cmp_en = 1;

        // Reset state
        chk("rst_pc", pc, 32'h0);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_retired", retired_cnt, 32'd0);
        rst_n = 1'b1;
        chk("idle_no_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        chk("first_req", 32'(imem_req), 32'd1);

        // Sequential fetch 0, 4, 8
        for (int i = 0; i < 3; i++) begin
            addr_seen[i] = imem_addr;
            exec_instr(BR_NOP, 0, 0, 0, 32'h0, 32'h0, 0);
        end
        for (int i = 0; i < 3; i++) chk("seq_addr", addr_seen[i], addr_exp[i]);
        chk("seq_retired", retired_cnt, 32'd3);
        chk("seq_pc", pc, 32'hC);
        exec_instr(BR_NOP, 0, 0, 0, 32'h0, 32'h0, 0);
        chk("seq_pc10", pc, 32'h10);

        // Taken / not-taken branch from 0x10
        exec_instr(BR_EQ, 1, 0, 0, 32'h20, 32'h0, 0);
        chk("br_taken_pc", pc, 32'h30);
        chk("br_taken_cnt", taken_cnt, 32'd1);
        exec_instr(BR_NOP, 0, 0, 1, 32'h0, 32'h10, 0);
        chk("jalr_back_pc", pc, 32'h10);
        exec_instr(BR_EQ, 0, 0, 0, 32'h20, 32'h0, 0);
        chk("br_nt_pc", pc, 32'h14);
        chk("br_nt_cnt", taken_cnt, 32'd2);
        exec_instr(BR_NOP, 1, 0, 0, 32'h20, 32'h0, 0);
        chk("br_nop_pc", pc, 32'h18);
        chk("br_nop_cnt", taken_cnt, 32'd2);
        exec_instr(BR_LTU, 1, 0, 0, 32'hFFFF_FFF8, 32'h0, 0);
        chk("br_back_pc", pc, 32'h10);

        // JALR beats JAL, bit 0 cleared
        exec_instr(BR_NOP, 0, 1, 1, 32'h4, 32'h101, 0);
        chk("jalr_pri_pc", pc, 32'h104);
        chk("jalr_pri_cnt", taken_cnt, 32'd4);

        // Delayed imem_valid: 3 request cycles at a stable address
        wait_exec();
        imem_valid = 1'b0;
        @(negedge clk);
        cnt = 0;
        for (int k = 0; k < 10 && !instr_valid; k++) begin
            if (imem_req && imem_addr == 32'h108) cnt++;
            if (cnt == 3) imem_valid = 1'b1;
            @(negedge clk);
        end
        chk("delay_req_cycles", 32'(cnt), 32'd3);

        // Stall over two EXEC edges: one instruction, three valid cycles
        cnt = 0;
        stall = 1'b1;
        repeat (3) begin
            if (instr_valid) cnt++;
            if (cnt == 3) stall = 1'b0;
            @(negedge clk);
        end
        chk("stall_valid_cycles", 32'(cnt), 32'd3);
        chk("stall_retired", retired_cnt, 32'd12);
        chk("stall_pc", pc, 32'h10C);

        // Halt beats jump at pc 0x8
        exec_instr(BR_NOP, 0, 0, 1, 32'h0, 32'h8, 0);
        exec_instr(BR_NOP, 0, 1, 0, 32'h40, 32'h0, 1);
        repeat (4) @(negedge clk);
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_pc", pc, 32'h8);
        chk("halt_retired", retired_cnt, 32'd13);
        chk("halt_no_req", 32'(imem_req), 32'd0);

        // Misaligned jump from 0 traps
        do_reset();
        exec_instr(BR_NOP, 0, 1, 0, 32'h6, 32'h0, 0);
        cnt = 0;
        repeat (5) begin
            if (imem_req) cnt++;
            @(negedge clk);
        end
        chk("trap_flag", 32'(misaligned), 32'd1);
        chk("trap_pc", pc, 32'h0);
        chk("trap_no_req", 32'(cnt), 32'd0);

        // Not-taken branch with odd offset never traps
        do_reset();
        exec_instr(BR_EQ, 0, 0, 0, 32'h6, 32'h0, 0);
        chk("nt_odd_pc", pc, 32'h4);
        chk("nt_odd_mis", 32'(misaligned), 32'd0);

        // Reset while in EXEC aborts without retiring
        wait_exec();
        jump = 1'b1; imm = 32'h8;
        #1 rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(instr_valid), 32'd0);
        chk("abort_pc", pc, 32'h0);
        chk("abort_retired", retired_cnt, 32'd0);
        clear_ctl();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Wrap-around from 0xFFFF_FFFC, then async reset mid-FETCH
        chk("wrap_rst_pc", pc2, 32'hFFFF_FFFC);
        chk("wrap_rst_plus4", pc_plus4_2, 32'h0);
        rst2_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("wrap_pc", pc2, 32'h0);
        chk("wrap_mis", 32'(misaligned2), 32'd0);
        chk("wrap_retired", retired2, 32'd1);
        chk("wrap_in_fetch", 32'(imem_req2), 32'd1);
        rst2_n = 1'b0;
        #1;
        chk("arst_pc", pc2, 32'hFFFF_FFFC);
        chk("arst_req", 32'(imem_req2), 32'd0);
        chk("arst_addr", imem_addr2, 32'hFFFF_FFFC);
        chk("arst_valid", 32'(instr_valid2), 32'd0);
        chk("arst_retired", retired2, 32'd0);
        chk("arst_taken", taken2, 32'd0);
        chk("arst_flags", {30'd0, misaligned2, halted2}, 32'd0);

        @(negedge clk);
        cmp_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
